// File: rtl/uart_pkg.sv
// Shared UART types and helpers: receiver state encoding, default frame
// geometry and the 3-sample majority vote used for bit recovery.
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    // Majority of three samples; a single glitched sample cannot flip the bit.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..BAUD_DIV-1 while enabled and emits a
// one-cycle tick on the last count. Dropping en_i holds the counter at 0, so
// the tick phase restarts cleanly when the enable is raised again.
module uart_baud_tick #(
    parameter int BAUD_DIV = 27
) (
    input  logic clock,
    input  logic reset,
    input  logic en_i,
    output logic tick_o
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt_q;

    // Free-running divider while enabled, parked at zero otherwise.
    always_ff @(posedge clock) begin
        if (reset || !en_i) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick_o = en_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver: synchronises rx_serial, recovers 8N1 frames with 16x
// oversampling and a 3-sample majority vote at mid-bit, and hands bytes to
// the consumer through a valid/ready handshake with framing/overrun pulses.
// Build option UART_RX_PARITY_EN adds a parity bit between data and stop,
// plus the parity_odd input and parity_err pulse output.
//
// state  | meaning
// IDLE   | line idle, waiting for a 1->0 edge on the synchronised line
// START  | validating the start bit at mid-bit (high vote = false start)
// DATA   | shifting payload bits in, LSB first
// PARITY | checking the parity bit (UART_RX_PARITY_EN builds only)
// STOP   | stop-bit vote; high completes the byte, low is a framing error
// BREAK  | line held low after a framing error; wait for it to go high
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int BAUD_DIV   = 27
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
`ifdef UART_RX_PARITY_EN
    ,
    input  logic                 parity_odd,
    output logic                 parity_err
`endif
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] SAMP_LO   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SAMP_MID  = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] SAMP_HI   = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    rx_state_t            state_q;
    logic                 rx_meta_q;
    logic                 rxs_q;
    logic                 rxs_prev_q;
    logic [SW-1:0]        samp_q;
    logic [BW-1:0]        bit_q;
    logic                 vote_lo_q;
    logic                 vote_mid_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic                 done_q;
    logic                 frame_err_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 overrun_q;

    logic                 tick;
    logic                 mid_tick;
    logic                 wrap_tick;
    logic                 vote_d;
    logic                 fall_d;

`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q;
    logic                 parity_err_q;
    logic                 par_bad_d;
`endif

    // Two-flop synchroniser plus a history flop for start-edge detection.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            rx_meta_q  <= rx_serial;
            rxs_q      <= rx_meta_q;
            rxs_prev_q <= rxs_q;
        end
    end

    uart_baud_tick #(
        .BAUD_DIV(BAUD_DIV)
    ) u_baud_tick (
        .clock (clock),
        .reset (reset),
        .en_i  (state_q != IDLE),
        .tick_o(tick)
    );

    assign mid_tick  = tick && (samp_q == SAMP_HI);
    assign wrap_tick = tick && (samp_q == SAMP_LAST);
    assign vote_d    = majority3(vote_lo_q, vote_mid_q, rxs_q);
    assign fall_d    = rxs_prev_q && !rxs_q;

`ifdef UART_RX_PARITY_EN
    assign par_bad_d = ((^shreg_q) ^ vote_d) != parity_odd;
`endif

    // Sample counter within a bit period and capture of the first two votes.
    always_ff @(posedge clock) begin
        if (reset || state_q == IDLE) begin
            samp_q     <= '0;
            vote_lo_q  <= 1'b1;
            vote_mid_q <= 1'b1;
        end else if (tick) begin
            samp_q <= (samp_q == SAMP_LAST) ? '0 : samp_q + 1'b1;
            if (samp_q == SAMP_LO) begin
                vote_lo_q <= rxs_q;
            end
            if (samp_q == SAMP_MID) begin
                vote_mid_q <= rxs_q;
            end
        end
    end

    // Frame sequencing: start validation, data shift, stop check, break hold.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            bit_q        <= '0;
            shreg_q      <= '0;
            done_q       <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            done_q       <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    bit_q <= '0;
`ifdef UART_RX_PARITY_EN
                    par_bad_q <= 1'b0;
`endif
                    if (fall_d) begin
                        state_q <= START;
                    end
                end
                START: begin
                    if (mid_tick && vote_d) begin
                        state_q <= IDLE;
                    end else if (wrap_tick) begin
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (mid_tick) begin
                        shreg_q <= {vote_d, shreg_q[DATA_BITS-1:1]};
                    end
                    if (wrap_tick) begin
                        if (bit_q == BIT_LAST) begin
                            bit_q <= '0;
`ifdef UART_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (mid_tick) begin
                        par_bad_q    <= par_bad_d;
                        parity_err_q <= par_bad_d;
                    end
                    if (wrap_tick) begin
                        state_q <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (mid_tick) begin
                        if (vote_d) begin
`ifdef UART_RX_PARITY_EN
                            done_q <= !par_bad_q;
`else
                            done_q <= 1'b1;
`endif
                            state_q <= IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (rxs_q) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Consumer handshake: load on completion unless an unaccepted byte is held.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (done_q) begin
                if (rx_valid_q && !rx_ready) begin
                    overrun_q <= 1'b1;
                end else begin
                    rx_data_q  <= shreg_q;
                    rx_valid_q <= 1'b1;
                end
            end else if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: drives serial frames at 64 clocks
// per bit, pushes expected bytes to a scoreboard and compares them against
// bytes the consumer accepts; pulse outputs are counted by a monitor.
module tb_uart_rx_frame;

    localparam int BAUD_DIV = 4;
    localparam int OS       = 16;
    localparam int DB       = 8;
    localparam int BIT_CLKS = BAUD_DIV * OS;
    // Start-bit drive to rx_valid rise: 2 sync flops + edge detect, the
    // stop-bit vote tick, then completion flag and output register.
    localparam int LAT      = 4 + BAUD_DIV * (OS * (DB + 1) + OS / 2 + 2);

    logic          clock;
    logic          reset;
    logic          rx_serial;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          frame_err;
    logic          overrun;
    logic          busy;
`ifdef UART_RX_PARITY_EN
    logic          parity_odd;
    logic          parity_err;
`endif

    uart_rx_frame #(
        .DATA_BITS (DB),
        .OVERSAMPLE(OS),
        .BAUD_DIV  (BAUD_DIV)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .rx_serial (rx_serial),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_odd(parity_odd),
        .parity_err(parity_err)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: records accepted bytes and counts pulse-output cycles.
    logic [DB-1:0] got_mem [0:255];
    int n_got      = 0;
    int n_ferr     = 0;
    int n_ovr      = 0;
    int n_perr     = 0;
    int last_rise  = -1;
    logic valid_prev = 1'b0;

    always @(negedge clock) begin
        if (rx_valid && rx_ready && n_got < 256) begin
            got_mem[n_got] = rx_data;
            n_got++;
        end
        if (rx_valid && !valid_prev) last_rise = cyc;
        valid_prev = rx_valid;
        if (frame_err) n_ferr++;
        if (overrun) n_ovr++;
`ifdef UART_RX_PARITY_EN
        if (parity_err) n_perr++;
`endif
    end

    int n_checks = 0;
    int n_errors = 0;
    logic [DB-1:0] exp_q[$];
    int rd_idx    = 0;
    int start_cyc = 0;
    int b_ferr, b_ovr, b_perr, b_got;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // One bit period; optionally inverts the line for one clock at spike_at.
    task automatic drive_bit(input logic b, input int spike_at);
        rx_serial = b;
        if (spike_at >= 0) begin
            repeat (spike_at) @(posedge clock);
            #1 rx_serial = ~b;
            @(posedge clock);
            #1 rx_serial = b;
            repeat (BIT_CLKS - spike_at - 1) @(posedge clock);
        end else begin
            repeat (BIT_CLKS) @(posedge clock);
        end
        #1;
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic stop_v,
                              input bit use_par, input logic par_v, input int spike_bit);
        start_cyc = cyc;
        drive_bit(1'b0, -1);
        for (int i = 0; i < DB; i++) drive_bit(d[i], (i == spike_bit) ? 36 : -1);
        if (use_par) drive_bit(par_v, -1);
        drive_bit(stop_v, -1);
    endtask

    task automatic snap();
        b_ferr = n_ferr;
        b_ovr  = n_ovr;
        b_perr = n_perr;
        b_got  = n_got;
    endtask

    task automatic drain();
        while (rd_idx < n_got) begin
            if (exp_q.size() == 0) begin
                check("sb_extra_byte", {24'd0, got_mem[rd_idx]}, 32'h100);
            end else begin
                check("sb_data", {24'd0, got_mem[rd_idx]}, {24'd0, exp_q.pop_front()});
            end
            rd_idx++;
        end
        check("sb_pending", exp_q.size(), 0);
    endtask

    initial begin
        reset     = 1'b1;
        rx_serial = 1'b1;
        rx_ready  = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_odd = 1'b0;
`endif
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_rx_data", {24'd0, rx_data}, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        @(posedge clock);
        #1 reset = 1'b0;
        idle(5);

        // Single byte, consumer always ready; check end-to-end latency.
        rx_ready = 1'b1;
        snap();
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, -1);
        idle(20);
        drain();
        check("a5_latency", last_rise - start_cyc, LAT);
        check("a5_frame_err", n_ferr - b_ferr, 0);
        check("a5_overrun", n_ovr - b_ovr, 0);

        // Back-to-back with consumer stalled: second byte dropped, overrun once.
        rx_ready = 1'b0;
        snap();
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, -1);
        send_frame(8'h81, 1'b1, 1'b0, 1'b0, -1);
        idle(10);
        check("ovr_valid_held", rx_valid, 1);
        check("ovr_data_kept", {24'd0, rx_data}, 32'h3C);
        check("ovr_pulses", n_ovr - b_ovr, 1);
        rx_ready = 1'b1;
        idle(2);
        check("ovr_valid_cleared", rx_valid, 0);
        drain();

        // Stop bit low, then line held low: one frame_err, busy until release.
        snap();
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, -1);
        rx_serial = 1'b0;
        idle(3 * BIT_CLKS);
        check("brk_busy_low_line", busy, 1);
        check("brk_frame_err", n_ferr - b_ferr, 1);
        rx_serial = 1'b1;
        idle(20);
        check("brk_busy_released", busy, 0);
        check("brk_no_byte", n_got - b_got, 0);

        // 20-clock glitch in IDLE: false start, nothing reported.
        snap();
        rx_serial = 1'b0;
        idle(20);
        rx_serial = 1'b1;
        idle(10);
        check("glitch_busy", busy, 1);
        idle(60);
        check("glitch_idle", busy, 0);
        check("glitch_no_byte", n_got - b_got, 0);
        check("glitch_frame_err", n_ferr - b_ferr, 0);

        // One-clock spike on the middle sample of bit 3 of 0x00.
        exp_q.push_back(8'h00);
        send_frame(8'h00, 1'b1, 1'b0, 1'b0, 3);
        idle(20);
        drain();

        // Reset during data bit 4 of 0xFF, then a clean 0x12.
        snap();
        drive_bit(1'b0, -1);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, -1);
        rx_serial = 1'b1;
        idle(30);
        reset = 1'b1;
        idle(3);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_valid", rx_valid, 0);
        reset = 1'b0;
        idle(100);
        check("rst_mid_no_byte", n_got - b_got, 0);
        check("rst_mid_frame_err", n_ferr - b_ferr, 0);
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1, 1'b0, 1'b0, -1);
        idle(20);
        drain();

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 needs parity bit 1; sending 0 must be rejected.
        parity_odd = 1'b0;
        snap();
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, -1);
        idle(20);
        check("par_err_pulse", n_perr - b_perr, 1);
        check("par_no_byte", n_got - b_got, 0);
        snap();
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, -1);
        idle(20);
        check("par_ok_no_err", n_perr - b_perr, 0);
        drain();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
